operand2_sequencer: RTL and testbench
=====================================

# operand2_sequencer

Multi-cycle controller that sequences the barrel shifter for ARM data-processing operand 2. On a start pulse it decodes the 12-bit operand-2 field, fetches Rm and optionally Rs through a synchronous register-file read port, and drives the shifter's base/amount/rg/typ/carry inputs. It then registers the shifter's operand and carry-out and pulses done. It sits between instruction decode and the ALU and is the shifter's only driver.

## Interface
- No parameters.
- clk  in  1  core clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- flush  in  1  synchronous abort; returns to IDLE, no done
- imm  in  1  instruction bit 25 (1 = rotated immediate)
- op2  in  12  instruction bits [11:0]
- pc  in  32  address of the current instruction
- c_flag  in  1  CPSR C, sampled with start
- rf_re  out  1  register-file read enable
- rf_addr  out  4  register-file read address
- rf_data  in  32  read data, valid the cycle after rf_re
- sh_base  out  32  to shifter base
- sh_amount  out  8  to shifter amount
- sh_rg  out  1  to shifter rg (1 = register-specified or immediate-rotate form)
- sh_typ  out  2  to shifter typ
- sh_fc  out  1  to shifter f_c
- sh_operand  in  32  from shifter operand
- sh_co  in  1  from shifter co
- result  out  32  registered operand 2
- carry_out  out  1  registered shifter carry
- done  out  1  one-cycle pulse, result valid
- busy  out  1  high in every non-IDLE state

## Operation
- States: IDLE, RD_RM, RD_RS, WT, EXEC.
- In IDLE with start=1, latch op2, imm, c_flag and pc.
  - If imm=1, go to EXEC.
  - If imm=0, go to RD_RM.
- Immediate form (imm=1):
  - base_q = {24'h0, op2[7:0]}.
  - amt_q = {3'b0, op2[11:8], 1'b0}.
  - typ = 2'b11, rg = 1.
- Immediate-shift form (imm=0, op2[4]=0):
  - RD_RM: rf_re=1, rf_addr=op2[3:0].
  - WT: base_q <= Rm.
  - amt_q = {3'b0, op2[11:7]}, typ = op2[6:5], rg = 0.
- Register-shift form (imm=0, op2[4]=1):
  - RD_RM: read Rm.
  - RD_RS: base_q <= Rm, read Rs = op2[11:8].
  - WT: amt_q <= Rs[7:0].
  - typ = op2[6:5], rg = 1.
- R15 is never read from the register file. When Rm or Rs = 15, rf_re stays 0 and the value is substituted:
  - pc+8 for immediate-shift form.
  - pc+12 for register-shift form.
  - Use 32-bit wrapping adds.
- EXEC: sh_base=base_q, sh_amount=amt_q, sh_rg, sh_typ, sh_fc=latched C. At the end of EXEC, result <= sh_operand and carry_out <= sh_co. Next state is IDLE and done=1.
- Outside EXEC, sh_* hold their last registered values and rf_re=0 except in read states.
- flush has priority over all transitions except reset. It forces IDLE without changing result or carry_out; no done.
- start while busy=1 is ignored and not queued.

## Timing
- The start cycle is cycle 0. done is asserted in cycle:
  - 2 for immediate form.
  - 4 for immediate-shift form.
  - 5 for register-shift form.
- done is high in the IDLE cycle following EXEC. busy=0 in that cycle and a new start is accepted in it, giving back-to-back operations.
- result and carry_out hold until the next EXEC completes.
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - result = 0, carry_out = 0, done = 0, busy = 0, rf_re = 0, rf_addr = 0.
  - sh_base = 0, sh_amount = 0, sh_rg = 0, sh_typ = 0, sh_fc = 0.
- Reset during any state aborts the operation; no done follows.

## Test plan
- Immediate: imm=1, op2=12'h4FF, c_flag=0 -> sh_typ=11, sh_amount=8, result=32'hFF000000, carry_out=1, done at cycle 2, rf_re never asserted.
- Immediate, rot 0: imm=1, op2=12'h0A5, c_flag=1 -> result=32'h000000A5, carry_out=1 (f_c passthrough).
- LSR #32 encoding: imm=0, op2=12'h023 (shift_imm 0, typ 01, Rm=r3), r3=32'h80000001 -> rf_addr=3 in cycle 1, sh_rg=0, result=0, carry_out=1, done at cycle 4.
- Register ROR: op2=12'h473 (Rs=r4, ROR, Rm=r3), r3=32'h80000000, r4=32'h00000120 -> reads r3 then r4, sh_amount=8'h20, result=32'h80000000, carry_out=1, done at cycle 5.
- PC substitution, pc=32'h08000000:
  - op2=12'h00F -> result=32'h08000008, no rf_re.
  - op2=12'h11F with r1=0, c_flag=1 -> result=32'h0800000C, carry_out=1.
- Abort: flush in WT -> no done, busy=0 next cycle, following start completes normally. rst_n low in EXEC -> all outputs 0 immediately, no done after release. A start issued on the done cycle completes with correct latency.

Source files
------------

// File: rtl/operand2_sequencer.sv
// Operand-2 sequencer: decodes the ARM operand-2 field, fetches Rm/Rs through a
// synchronous register-file port, drives the barrel shifter and registers its result.
module operand2_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        imm,
  input  logic [11:0] op2,
  input  logic [31:0] pc,
  input  logic        c_flag,
  output logic        rf_re,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] sh_base,
  output logic [7:0]  sh_amount,
  output logic        sh_rg,
  output logic [1:0]  sh_typ,
  output logic        sh_fc,
  input  logic [31:0] sh_operand,
  input  logic        sh_co,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_RM = 3'd1;
  localparam logic [2:0] S_RD_RS = 3'd2;
  localparam logic [2:0] S_WT    = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [11:0] op2_q, op2_d;
  logic        imm_q, imm_d;
  logic        c_q, c_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] base_q, base_d;
  logic [7:0]  amt_q, amt_d;

  logic [31:0] sh_base_q;
  logic [7:0]  sh_amount_q;
  logic        sh_rg_q;
  logic [1:0]  sh_typ_q;
  logic        sh_fc_q;
  logic [31:0] result_q;
  logic        carry_q;
  logic        done_q;

  logic [3:0]  rm, rs;
  logic        reg_shift, rm_is_pc, rs_is_pc;
  logic [31:0] pc_plus8, pc_plus12;
  logic        enter_exec, exec_done;

  assign rm        = op2_q[3:0];
  assign rs        = op2_q[11:8];
  assign reg_shift = op2_q[4];
  assign rm_is_pc  = (rm == 4'd15);
  assign rs_is_pc  = (rs == 4'd15);
  // R15 reads see the pipeline PC: +8 normally, +12 when a shift register is also read.
  assign pc_plus8  = pc_q + 32'd8;
  assign pc_plus12 = pc_q + 32'd12;

  // NOTE: every combinationally assigned signal gets a default first so no path
  // through the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    c_d     = c_q;
    pc_d    = pc_q;
    base_d  = base_q;
    amt_d   = amt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op2_d = op2;
          imm_d = imm;
          c_d   = c_flag;
          pc_d  = pc;
          if (imm) begin
            base_d  = {24'h0, op2[7:0]};
            amt_d   = {3'b0, op2[11:8], 1'b0};
            state_d = S_EXEC;
          end else begin
            state_d = S_RD_RM;
          end
        end
      end
      S_RD_RM: state_d = reg_shift ? S_RD_RS : S_WT;
      S_RD_RS: begin
        base_d  = rm_is_pc ? pc_plus12 : rf_data;
        state_d = S_WT;
      end
      S_WT: begin
        if (reg_shift) begin
          amt_d = rs_is_pc ? pc_plus12[7:0] : rf_data[7:0];
        end else begin
          base_d = rm_is_pc ? pc_plus8 : rf_data;
          amt_d  = {3'b0, op2_q[11:7]};
        end
        state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign enter_exec = (state_d == S_EXEC);
  assign exec_done  = (state_q == S_EXEC) && !flush;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op2_q       <= '0;
      imm_q       <= 1'b0;
      c_q         <= 1'b0;
      pc_q        <= '0;
      base_q      <= '0;
      amt_q       <= '0;
      sh_base_q   <= '0;
      sh_amount_q <= '0;
      sh_rg_q     <= 1'b0;
      sh_typ_q    <= '0;
      sh_fc_q     <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      c_q     <= c_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      amt_q   <= amt_d;
      // Shifter inputs change only on entry to EXEC and hold between operations.
      if (enter_exec) begin
        sh_base_q   <= base_d;
        sh_amount_q <= amt_d;
        sh_rg_q     <= imm_d | op2_d[4];
        sh_typ_q    <= imm_d ? 2'b11 : op2_d[6:5];
        sh_fc_q     <= c_d;
      end
      if (exec_done) begin
        result_q <= sh_operand;
        carry_q  <= sh_co;
      end
      done_q <= exec_done;
    end
  end

  always_comb begin
    rf_re   = 1'b0;
    rf_addr = 4'd0;
    if (state_q == S_RD_RM) begin
      rf_addr = rm;
      rf_re   = !rm_is_pc;
    end else if (state_q == S_RD_RS) begin
      rf_addr = rs;
      rf_re   = !rs_is_pc;
    end
  end

  assign sh_base   = sh_base_q;
  assign sh_amount = sh_amount_q;
  assign sh_rg     = sh_rg_q;
  assign sh_typ    = sh_typ_q;
  assign sh_fc     = sh_fc_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_operand2_sequencer.sv
// Bench for operand2_sequencer: register file and barrel shifter stand-ins, a
// transaction-level reference model checked every cycle, and directed vectors.
module tb_operand2_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, imm, c_flag;
  logic [11:0] op2;
  logic [31:0] pc;
  logic        rf_re;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] sh_base;
  logic [7:0]  sh_amount;
  logic        sh_rg, sh_fc;
  logic [1:0]  sh_typ;
  logic [31:0] sh_operand;
  logic        sh_co;
  logic [31:0] result;
  logic        carry_out, done, busy;

  operand2_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .imm(imm), .op2(op2),
    .pc(pc), .c_flag(c_flag), .rf_re(rf_re), .rf_addr(rf_addr), .rf_data(rf_data),
    .sh_base(sh_base), .sh_amount(sh_amount), .sh_rg(sh_rg), .sh_typ(sh_typ),
    .sh_fc(sh_fc), .sh_operand(sh_operand), .sh_co(sh_co), .result(result),
    .carry_out(carry_out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ARM barrel shifter semantics; returns {carry, operand}.
  function automatic logic [32:0] shift_op(input logic [31:0] b, input logic [7:0] n,
                                           input logic [1:0] typ, input logic rg, input logic c);
    int k;
    int r;
    k = int'(n);
    if (k == 0) begin
      if (rg || typ == 2'd0) return {c, b};
      case (typ)
        2'd1:    return {b[31], 32'h0};
        2'd2:    return {b[31], {32{b[31]}}};
        default: return {b[0], c, b[31:1]};
      endcase
    end
    case (typ)
      2'd0: begin
        if (k < 32) return {b[32-k], b << k};
        if (k == 32) return {b[0], 32'h0};
        return 33'h0;
      end
      2'd1: begin
        if (k < 32) return {b[k-1], b >> k};
        if (k == 32) return {b[31], 32'h0};
        return 33'h0;
      end
      2'd2: begin
        if (k < 32) return {b[k-1], 32'($signed(b) >>> k)};
        return {b[31], {32{b[31]}}};
      end
      default: begin
        r = k % 32;
        if (r == 0) return {b[31], b};
        return {b[r-1], (b >> r) | (b << (32 - r))};
      end
    endcase
  endfunction

  // Shifter stand-in.
  always_comb {sh_co, sh_operand} = shift_op(sh_base, sh_amount, sh_typ, sh_rg, sh_fc);

  // Synchronous register-file stand-in; garbage when not enabled.
  logic [31:0] regs [16];
  int rf_cnt = 0;
  always @(posedge clk) begin
    rf_data <= rf_re ? regs[rf_addr] : 32'hDEAD_BEEF;
    if (rf_re) rf_cnt <= rf_cnt + 1;
  end

  typedef struct {
    int          lat;
    logic        rd1_en;
    logic [3:0]  rd1;
    logic        rd2_en;
    logic [3:0]  rd2;
    logic [31:0] base;
    logic [7:0]  amt;
    logic [1:0]  typ;
    logic        rg;
    logic        fc;
    logic [31:0] res;
    logic        co;
  } plan_t;

  function automatic plan_t decode(input logic i, input logic [11:0] o,
                                   input logic [31:0] p, input logic c);
    plan_t q;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [31:0] rsv;
    logic [32:0] s;
    rm = o[3:0];
    rs = o[11:8];
    q.fc = c;
    q.rd1 = rm;
    q.rd2 = rs;
    q.rd1_en = 1'b0;
    q.rd2_en = 1'b0;
    if (i) begin
      q.lat = 2; q.base = {24'h0, o[7:0]}; q.amt = {3'b0, o[11:8], 1'b0};
      q.typ = 2'b11; q.rg = 1'b1;
    end else if (!o[4]) begin
      q.lat = 4; q.rd1_en = (rm != 4'd15);
      q.base = (rm == 4'd15) ? p + 32'd8 : regs[rm];
      q.amt = {3'b0, o[11:7]}; q.typ = o[6:5]; q.rg = 1'b0;
    end else begin
      q.lat = 5; q.rd1_en = (rm != 4'd15); q.rd2_en = (rs != 4'd15);
      q.base = (rm == 4'd15) ? p + 32'd12 : regs[rm];
      rsv = (rs == 4'd15) ? p + 32'd12 : regs[rs];
      q.amt = rsv[7:0]; q.typ = o[6:5]; q.rg = 1'b1;
    end
    s = shift_op(q.base, q.amt, q.typ, q.rg, q.fc);
    q.res = s[31:0];
    q.co = s[32];
    return q;
  endfunction

  // Reference model state, advanced once per cycle by the compare process.
  plan_t       m_p;
  logic        m_act = 1'b0;
  int          m_t = 0;
  logic [31:0] m_base, m_res;
  logic [7:0]  m_amt;
  logic [1:0]  m_typ;
  logic        m_rg, m_fc, m_co;

  always @(negedge clk) begin
    logic exp_busy, exp_done, exp_re, accept;
    if (!rst_n) begin
      check("rst_result", result, 0);    check("rst_carry", carry_out, 0);
      check("rst_done", done, 0);        check("rst_busy", busy, 0);
      check("rst_rf_re", rf_re, 0);      check("rst_rf_addr", rf_addr, 0);
      check("rst_sh_base", sh_base, 0);  check("rst_sh_amount", sh_amount, 0);
      check("rst_sh_rg", sh_rg, 0);      check("rst_sh_typ", sh_typ, 0);
      check("rst_sh_fc", sh_fc, 0);
      m_act = 1'b0; m_base = '0; m_amt = '0; m_typ = '0; m_rg = 1'b0; m_fc = 1'b0;
      m_res = '0; m_co = 1'b0;
    end else begin
      if (m_act) m_t++;
      exp_busy = m_act && (m_t < m_p.lat);
      exp_done = m_act && (m_t == m_p.lat);
      exp_re   = m_act && ((m_t == 1 && m_p.rd1_en) || (m_t == 2 && m_p.lat == 5 && m_p.rd2_en));
      if (m_act && m_t == m_p.lat - 1) begin
        m_base = m_p.base; m_amt = m_p.amt; m_typ = m_p.typ; m_rg = m_p.rg; m_fc = m_p.fc;
      end
      if (exp_done) begin
        m_res = m_p.res; m_co = m_p.co;
      end
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("rf_re", rf_re, exp_re);
      if (exp_re) check("rf_addr", rf_addr, (m_t == 1) ? m_p.rd1 : m_p.rd2);
      check("sh_base", sh_base, m_base);   check("sh_amount", sh_amount, m_amt);
      check("sh_typ", sh_typ, m_typ);      check("sh_rg", sh_rg, m_rg);
      check("sh_fc", sh_fc, m_fc);
      check("result", result, m_res);      check("carry_out", carry_out, m_co);
      accept = start && !exp_busy && !flush;
      if (m_act && (exp_done || flush)) m_act = 1'b0;
      if (accept) begin
        m_p = decode(imm, op2, pc, c_flag);
        m_act = 1'b1;
        m_t = 0;
      end
    end
  end

  // Drives a one-cycle start from posedge+1; returns in cycle 1 with inputs scrambled.
  task automatic issue(input logic i, input logic [11:0] o, input logic [31:0] p, input logic c);
    imm = i; op2 = o; pc = p; c_flag = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; imm = ~i; op2 = ~o; pc = ~p; c_flag = ~c;
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  int lat, n0;
  logic [11:0] extra_ops [5];

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; imm = 1'b0; op2 = '0; pc = '0; c_flag = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1111_0000 + i;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Rotated immediate, rotate by 8.
    n0 = rf_cnt;
    issue(1'b1, 12'h4FF, 32'h0000_0100, 1'b0);
    check("imm_sh_typ", sh_typ, 2'b11);
    check("imm_sh_amount", sh_amount, 8);
    wait_done(1, lat);
    check("imm_latency", lat, 2);
    check("imm_result", result, 32'hFF00_0000);
    check("imm_carry", carry_out, 1);
    check("imm_no_rf_read", rf_cnt - n0, 0);

    // Rotated immediate, rotate 0: carry is the latched C flag.
    issue(1'b1, 12'h0A5, 32'h0, 1'b1);
    wait_done(1, lat);
    check("imm0_result", result, 32'h0000_00A5);
    check("imm0_carry", carry_out, 1);

    // LSR #32 encoding.
    regs[3] = 32'h8000_0001;
    issue(1'b0, 12'h023, 32'h0, 1'b0);
    check("lsr_rf_re", rf_re, 1);
    check("lsr_rf_addr", rf_addr, 3);
    wait_done(1, lat);
    check("lsr_latency", lat, 4);
    check("lsr_result", result, 32'h0);
    check("lsr_carry", carry_out, 1);
    check("lsr_sh_rg", sh_rg, 0);

    // Register-specified ROR by 32; a start while busy is ignored.
    regs[3] = 32'h8000_0000;
    regs[4] = 32'h0000_0120;
    issue(1'b0, 12'h473, 32'h0, 1'b0);
    check("ror_rd_rm", rf_addr, 3);
    @(posedge clk); #1;
    check("ror_rd_rs", rf_addr, 4);
    check("ror_rd_rs_re", rf_re, 1);
    imm = 1'b1; op2 = 12'h0FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat);
    check("ror_latency", lat, 5);
    check("ror_sh_amount", sh_amount, 8'h20);
    check("ror_result", result, 32'h8000_0000);
    check("ror_carry", carry_out, 1);

    // PC substitution.
    n0 = rf_cnt;
    issue(1'b0, 12'h00F, 32'h0800_0000, 1'b0);
    wait_done(1, lat);
    check("pc8_latency", lat, 4);
    check("pc8_result", result, 32'h0800_0008);
    check("pc8_no_rf_read", rf_cnt - n0, 0);
    regs[1] = 32'h0;
    n0 = rf_cnt;
    issue(1'b0, 12'h11F, 32'h0800_0000, 1'b1);
    wait_done(1, lat);
    check("pc12_latency", lat, 5);
    check("pc12_result", result, 32'h0800_000C);
    check("pc12_carry", carry_out, 1);
    check("pc12_one_rf_read", rf_cnt - n0, 1);

    // Flush in WT: no done, result unchanged, next op completes.
    regs[3] = 32'h8000_0001;
    issue(1'b0, 12'h023, 32'h0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_result_held", result, 32'h0800_000C);
    repeat (3) @(posedge clk);
    #1;
    issue(1'b1, 12'h4FF, 32'h0, 1'b0);
    wait_done(1, lat);
    check("post_flush_latency", lat, 2);
    check("post_flush_result", result, 32'hFF00_0000);

    // Reset in EXEC.
    issue(1'b1, 12'h0A5, 32'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_exec_result", result, 0);
    check("rst_exec_carry", carry_out, 0);
    check("rst_exec_busy", busy, 0);
    check("rst_exec_sh_base", sh_base, 0);
    check("rst_exec_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
    end

    // Back-to-back: start on the done cycle.
    issue(1'b0, 12'h023, 32'h0, 1'b0);
    wait_done(1, lat);
    check("b2b_first_latency", lat, 4);
    check("b2b_idle_on_done", busy, 0);
    issue(1'b1, 12'h4FF, 32'h0, 1'b0);
    wait_done(1, lat);
    check("b2b_second_latency", lat, 2);
    check("b2b_result", result, 32'hFF00_0000);

    // Further shift forms, checked by the model each cycle.
    regs[2] = 32'h0000_0021;
    regs[3] = 32'hF000_000F;
    extra_ops[0] = 12'h143;
    extra_ops[1] = 12'h063;
    extra_ops[2] = 12'h253;
    extra_ops[3] = 12'h233;
    extra_ops[4] = 12'hF00;
    for (int i = 0; i < 5; i++) begin
      issue((i == 4), extra_ops[i], 32'h0000_1000, i[0]);
      wait_done(1, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
